// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module : ps2_host_tx
// Host-to-device PS/2 command transmitter driving open-drain clock/data lines.
// Rev    : 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_CYCLES     = 200,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2clk_in,
  input  logic       ps2dat_in,
  output logic       ps2clk_oe,
  output logic       ps2dat_oe
);

  localparam int CW = $clog2((INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int FW = $clog2(FILTER_CYCLES) + 1;

  localparam logic [CW-1:0] c_inh_last = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] c_req_last = CW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] c_to_last  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] c_flt_last = FW'(FILTER_CYCLES - 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_inhibit = 3'd1;
  localparam logic [2:0] c_st_req     = 3'd2;
  localparam logic [2:0] c_st_bits    = 3'd3;
  localparam logic [2:0] c_st_ack     = 3'd4;
  localparam logic [2:0] c_st_wait    = 3'd5;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic       w_fall;
  logic       w_idle;

  assign w_raw = {ps2dat_in, ps2clk_in};

  // Index 0 is the clock line, index 1 the data line; both idle high.
  for (genvar gi = 0; gi < 2; gi++) begin : g_filter
    logic          r_s1;
    logic          r_s2;
    logic          r_f;
    logic [FW-1:0] r_fcnt;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_s1   <= 1'b1;
        r_s2   <= 1'b1;
        r_f    <= 1'b1;
        r_fcnt <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_f) begin
          r_fcnt <= '0;
        end else if (r_fcnt == c_flt_last) begin
          r_f    <= r_s2;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end

    assign w_filt[gi] = r_f;
  end

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_to;
  logic [3:0]    r_idx;
  logic [7:0]    r_data;
  logic          r_par;
  logic          r_clk_d;
  logic          r_clk_oe;
  logic          r_dat_oe;
  logic          r_done;
  logic          r_err;

  assign w_fall = r_clk_d & ~w_filt[0];
  assign w_idle = (r_state == c_st_idle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= c_st_idle;
      r_cnt    <= '0;
      r_to     <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_clk_d  <= 1'b1;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_clk_d <= w_filt[0];
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (tx_valid) begin
            r_data   <= tx_data;
            r_par    <= ~^tx_data;
            r_clk_oe <= 1'b1;
            r_cnt    <= '0;
            r_state  <= c_st_inhibit;
          end
        end
        c_st_inhibit: begin
          if (r_cnt == c_inh_last) begin
            r_cnt    <= '0;
            r_dat_oe <= 1'b1;
            r_state  <= c_st_req;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_req: begin
          if (r_cnt == c_req_last) begin
            r_cnt    <= '0;
            r_to     <= '0;
            r_idx    <= '0;
            r_clk_oe <= 1'b0;
            r_state  <= c_st_bits;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_bits, c_st_ack, c_st_wait: begin
          if (w_fall) begin
            r_to <= '0;
          end else begin
            r_to <= r_to + 1'b1;
          end
          if (r_state == c_st_bits && w_fall) begin
            // Fall n presents bit n-1 of {stop, parity, data[7:0]}.
            r_idx <= r_idx + 1'b1;
            if (r_idx < 4'd8) begin
              r_dat_oe <= ~r_data[r_idx[2:0]];
            end else if (r_idx == 4'd8) begin
              r_dat_oe <= ~r_par;
            end else begin
              r_dat_oe <= 1'b0;
              r_state  <= c_st_ack;
            end
          end else if (r_state == c_st_ack && w_fall) begin
            if (!w_filt[1]) begin
              r_state <= c_st_wait;
            end else begin
              r_err   <= 1'b1;
              r_state <= c_st_idle;
            end
          end else if (r_state == c_st_wait && w_filt[0] && w_filt[1]) begin
            r_done  <= 1'b1;
            r_state <= c_st_idle;
          end else if (!w_fall && r_to == c_to_last) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= c_st_idle;
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= c_st_idle;
        end
      endcase
    end
  end

  assign tx_ready  = w_idle;
  assign busy      = ~w_idle;
  assign tx_done   = r_done;
  assign tx_err    = r_err;
  assign ps2clk_oe = r_clk_oe;
  assign ps2dat_oe = r_dat_oe;

endmodule
`default_nettype wire
